game_turn_ctrl: RTL and testbench
=================================

GAME_TURN_CTRL -- requirements
Module: game_turn_ctrl

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of players taking turns, legal range 2..4.
REQ-002 Parameter BOARD_CELLS, default 42, number of moves that fill the board.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000, cycles allowed per turn; used only when MOVE_TIMEOUT_EN is defined.
REQ-004 clk  in  1  clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  request a new game; sampled in IDLE and OVER only.
REQ-007 move_req  in  1  single-cycle pulse: the current player submits a move.
REQ-008 col_full  in  1  qualifies move_req; high means the selected column is full and the move is illegal.
REQ-009 check_done  in  1  single-cycle pulse from the win checker: the result is ready.
REQ-010 win_found  in  1  qualifies check_done; high means the last move won the game.
REQ-011 cur_player  out  2  index of the player to move, 0..NUM_PLAYERS-1.
REQ-012 status  out  2  game status: 00 IDLE, 01 PLAYING, 10 WIN, 11 TIE.
REQ-013 winner  out  2  winning player index; valid only while status=WIN.
REQ-014 move_ack  out  1  single-cycle pulse: the move was accepted.
REQ-015 move_reject  out  1  single-cycle pulse: the move was rejected because col_full was high.
REQ-016 check_start  out  1  single-cycle pulse that starts the win checker.
REQ-017 move_cnt  out  clog2(BOARD_CELLS+1)  number of moves accepted in the current game.
REQ-018 timeout  out  1  single-cycle pulse: the current turn was forfeited.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, TURN, CHECK, OVER.
REQ-020 In IDLE or OVER, start=1 SHALL move to TURN next cycle.
  - Same edge: cur_player=0, move_cnt=0, status=PLAYING.
REQ-021 In TURN, move_req=1 with col_full=1 SHALL pulse move_reject in the next cycle.
  - State stays TURN; cur_player and move_cnt unchanged.
REQ-022 In TURN, move_req=1 with col_full=0 SHALL move to CHECK.
  - move_ack and check_start pulse together in the next cycle.
  - move_cnt increments by 1 on the same edge.
REQ-023 In CHECK, move_req SHALL be ignored: no ack, no reject.
REQ-024 In CHECK, check_done=1 with win_found=1 SHALL move to OVER.
  - status=WIN, winner=cur_player.
REQ-025 In CHECK, check_done=1, win_found=0 and move_cnt==BOARD_CELLS SHALL move to OVER with status=TIE.
REQ-026 Otherwise, check_done=1 SHALL move to TURN.
  - cur_player advances by 1 and wraps from NUM_PLAYERS-1 to 0.
REQ-027 When check_done and win_found are both 1 on the last cell, WIN SHALL take priority over TIE.
REQ-028 start in TURN or CHECK SHALL be ignored.
REQ-029 In OVER, status, winner, cur_player and move_cnt SHALL hold until start or reset.
REQ-030 move_cnt SHALL saturate at BOARD_CELLS and never wrap.
REQ-031 All outputs SHALL be registered.
  - Latency from a qualifying input to the output response is exactly 1 cycle.

Reset
REQ-032 reset=1 SHALL force state IDLE immediately, without waiting for clk.
REQ-033 During reset: status=00, cur_player=0, winner=0, move_cnt=0, all pulse outputs 0, timeout counter 0.
REQ-034 Reset asserted mid-game SHALL abandon the game; a new game requires start after reset is released.

Configuration
REQ-035 Macro MOVE_TIMEOUT_EN SHALL compile in the per-turn timeout.
REQ-036 With MOVE_TIMEOUT_EN defined:
  - A counter clears on entry to TURN and increments each cycle spent in TURN.
  - When the counter reaches TIMEOUT_CYCLES-1 with no move_req, timeout pulses in the next cycle.
  - The turn is forfeited: cur_player advances with wrap and the state stays TURN.
  - move_cnt is unchanged and the counter clears.
  - A move_req on the expiry cycle is processed normally and no timeout pulse is produced.
REQ-037 Without MOVE_TIMEOUT_EN, no counter logic SHALL exist and timeout SHALL be tied to 0.

Verification
REQ-038 NUM_PLAYERS=3: start, then three legal moves with check_done and win_found=0 -> cur_player 0,1,2,0; move_cnt=3.
REQ-039 move_req with col_full=1 in TURN -> move_reject=1 for 1 cycle, no check_start, cur_player and move_cnt unchanged.
REQ-040 BOARD_CELLS=4: four legal moves with no win -> status=11 after the 4th check_done.
  - Repeat with win_found=1 on the 4th check_done -> status=10, winner=cur_player.
REQ-041 Reset asserted while in CHECK -> outputs return to reset values asynchronously.
  - check_done after reset is ignored; status stays 00.
REQ-042 MOVE_TIMEOUT_EN with TIMEOUT_CYCLES=8: idle in TURN -> timeout pulses 8 cycles after TURN entry and cur_player advances.
  - move_req on the expiry cycle -> move_ack is produced and no timeout pulse.

Source files
------------

// File: rtl/game_turn_ctrl.sv
// Turn sequencer for an N-player drop-piece board game: tracks the player to move, move count and result.
// Optional per-turn forfeit timer is compiled in with `define MOVE_TIMEOUT_EN.
module game_turn_ctrl #(
  parameter int unsigned NUM_PLAYERS    = 2,
  parameter int unsigned BOARD_CELLS    = 42,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             move_req,
  input  logic                             col_full,
  input  logic                             check_done,
  input  logic                             win_found,
  output logic [1:0]                       cur_player,
  output logic [1:0]                       status,
  output logic [1:0]                       winner,
  output logic                             move_ack,
  output logic                             move_reject,
  output logic                             check_start,
  output logic [$clog2(BOARD_CELLS+1)-1:0] move_cnt,
  output logic                             timeout
);

  localparam int unsigned    CW          = $clog2(BOARD_CELLS + 1);
  localparam logic [1:0]     LAST_PLAYER = 2'(NUM_PLAYERS - 1);
  localparam logic [CW-1:0]  CELLS       = CW'(BOARD_CELLS);

  if (NUM_PLAYERS < 2 || NUM_PLAYERS > 4 || BOARD_CELLS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("game_turn_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, TURN, CHECK, OVER} state_e;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PLAYING = 2'b01,
    ST_WIN     = 2'b10,
    ST_TIE     = 2'b11
  } status_e;

  state_e          state, state_nxt;
  status_e         status_q, status_nxt;
  logic [1:0]      player_q, player_nxt;
  logic [1:0]      winner_q, winner_nxt;
  logic [CW-1:0]   cnt_q, cnt_nxt;
  logic            ack_q, ack_nxt;
  logic            rej_q, rej_nxt;
  logic            chk_q, chk_nxt;

  function automatic logic [1:0] next_player(input logic [1:0] p);
    return (p == LAST_PLAYER) ? 2'd0 : p + 2'd1;
  endfunction

`ifdef MOVE_TIMEOUT_EN
  localparam int unsigned   TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
  logic          tmo_q, tmo_nxt;
  logic          tmo_expire;

  assign tmo_expire = (tmo_cnt == TMO_LAST);

  // Counter only runs while staying in TURN; entry, forfeit and the expiry cycle all restart it.
  always_comb begin
    tmo_cnt_nxt = '0;
    if (state == TURN && state_nxt == TURN && !tmo_expire)
      tmo_cnt_nxt = tmo_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_cnt <= tmo_cnt_nxt;
      tmo_q   <= tmo_nxt;
    end
  end

  assign timeout = tmo_q;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    status_nxt = status_q;
    player_nxt = player_q;
    winner_nxt = winner_q;
    cnt_nxt    = cnt_q;
    ack_nxt    = 1'b0;
    rej_nxt    = 1'b0;
    chk_nxt    = 1'b0;
`ifdef MOVE_TIMEOUT_EN
    tmo_nxt    = 1'b0;
`endif
    unique case (state)
      IDLE, OVER: begin
        if (start) begin
          state_nxt  = TURN;
          status_nxt = ST_PLAYING;
          player_nxt = '0;
          winner_nxt = '0;
          cnt_nxt    = '0;
        end
      end
      TURN: begin
        if (move_req) begin
          if (col_full) begin
            rej_nxt = 1'b1;
          end else begin
            state_nxt = CHECK;
            ack_nxt   = 1'b1;
            chk_nxt   = 1'b1;
            if (cnt_q != CELLS)
              cnt_nxt = cnt_q + 1'b1;
          end
        end
`ifdef MOVE_TIMEOUT_EN
        else if (tmo_expire) begin
          tmo_nxt    = 1'b1;
          player_nxt = next_player(player_q);
        end
`endif
      end
      CHECK: begin
        if (check_done) begin
          if (win_found) begin
            state_nxt  = OVER;
            status_nxt = ST_WIN;
            winner_nxt = player_q;
          end else if (cnt_q == CELLS) begin
            state_nxt  = OVER;
            status_nxt = ST_TIE;
          end else begin
            state_nxt  = TURN;
            player_nxt = next_player(player_q);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      status_q <= ST_IDLE;
      player_q <= '0;
      winner_q <= '0;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      rej_q    <= 1'b0;
      chk_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      status_q <= status_nxt;
      player_q <= player_nxt;
      winner_q <= winner_nxt;
      cnt_q    <= cnt_nxt;
      ack_q    <= ack_nxt;
      rej_q    <= rej_nxt;
      chk_q    <= chk_nxt;
    end
  end

  assign status      = status_q;
  assign cur_player  = player_q;
  assign winner      = winner_q;
  assign move_cnt    = cnt_q;
  assign move_ack    = ack_q;
  assign move_reject = rej_q;
  assign check_start = chk_q;

endmodule

// File: tb/tb_game_turn_ctrl.sv
// Directed self-checking bench for game_turn_ctrl with 3 players, 4-cell board, 8-cycle turn timeout.
module tb_game_turn_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       move_req = 1'b0;
  logic       col_full = 1'b0;
  logic       check_done = 1'b0;
  logic       win_found = 1'b0;
  logic [1:0] cur_player;
  logic [1:0] status;
  logic [1:0] winner;
  logic       move_ack;
  logic       move_reject;
  logic       check_start;
  logic [2:0] move_cnt;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  game_turn_ctrl #(
    .NUM_PLAYERS(3),
    .BOARD_CELLS(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .move_req(move_req),
    .col_full(col_full),
    .check_done(check_done),
    .win_found(win_found),
    .cur_player(cur_player),
    .status(status),
    .winner(winner),
    .move_ack(move_ack),
    .move_reject(move_reject),
    .check_start(check_start),
    .move_cnt(move_cnt),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic play_move(input logic win);
    move_req = 1'b1; col_full = 1'b0;
    tick();
    move_req = 1'b0;
    check_done = 1'b1; win_found = win;
    tick();
    check_done = 1'b0; win_found = 1'b0;
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL reset_status actual=%0d expected=0", status); end
    checks++; if (cur_player !== 2'd0) begin errors++; $display("FAIL reset_player actual=%0d expected=0", cur_player); end
    checks++; if (winner !== 2'd0) begin errors++; $display("FAIL reset_winner actual=%0d expected=0", winner); end
    checks++; if (move_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt actual=%0d expected=0", move_cnt); end
    checks++; if ({move_ack, move_reject, check_start, timeout} !== 4'b0000) begin
      errors++; $display("FAIL reset_pulses actual=%b expected=0000", {move_ack, move_reject, check_start, timeout});
    end
  endtask

  task automatic test_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (status !== 2'b01) begin errors++; $display("FAIL start_status actual=%0d expected=1", status); end
    checks++; if (cur_player !== 2'd0) begin errors++; $display("FAIL start_player actual=%0d expected=0", cur_player); end
    checks++; if (move_cnt !== 3'd0) begin errors++; $display("FAIL start_cnt actual=%0d expected=0", move_cnt); end
  endtask

  task automatic test_moves;
    logic [1:0] exp_p;
    for (int i = 0; i < 3; i++) begin
      move_req = 1'b1; col_full = 1'b0;
      tick();
      checks++; if ({move_ack, check_start} !== 2'b11) begin
        errors++; $display("FAIL move_ack_chk[%0d] actual=%b expected=11", i, {move_ack, check_start});
      end
      checks++; if (move_cnt !== 3'(i + 1)) begin errors++; $display("FAIL move_cnt[%0d] actual=%0d expected=%0d", i, move_cnt, i + 1); end
      // move_req still high while in CHECK must be ignored
      tick();
      move_req = 1'b0;
      checks++; if ({move_ack, move_reject, check_start} !== 3'b000) begin
        errors++; $display("FAIL check_ignore_move[%0d] actual=%b expected=000", i, {move_ack, move_reject, check_start});
      end
      check_done = 1'b1; win_found = 1'b0;
      tick();
      check_done = 1'b0;
      exp_p = 2'((i + 1) % 3);
      checks++; if (cur_player !== exp_p) begin errors++; $display("FAIL advance_player[%0d] actual=%0d expected=%0d", i, cur_player, exp_p); end
    end
    checks++; if (move_cnt !== 3'd3) begin errors++; $display("FAIL moves_total actual=%0d expected=3", move_cnt); end
  endtask

  task automatic test_reject;
    move_req = 1'b1; col_full = 1'b1; start = 1'b1;
    tick();
    move_req = 1'b0; col_full = 1'b0; start = 1'b0;
    checks++; if ({move_reject, move_ack, check_start} !== 3'b100) begin
      errors++; $display("FAIL reject_pulses actual=%b expected=100", {move_reject, move_ack, check_start});
    end
    checks++; if (cur_player !== 2'd0) begin errors++; $display("FAIL reject_player actual=%0d expected=0", cur_player); end
    checks++; if (move_cnt !== 3'd3) begin errors++; $display("FAIL reject_cnt actual=%0d expected=3", move_cnt); end
    tick();
    checks++; if (move_reject !== 1'b0) begin errors++; $display("FAIL reject_one_cycle actual=%0d expected=0", move_reject); end
    checks++; if (status !== 2'b01) begin errors++; $display("FAIL start_ignored_turn actual=%0d expected=1", status); end
  endtask

  task automatic test_tie;
    move_req = 1'b1;
    tick();
    move_req = 1'b0;
    checks++; if (move_cnt !== 3'd4) begin errors++; $display("FAIL tie_cnt actual=%0d expected=4", move_cnt); end
    check_done = 1'b1; win_found = 1'b0;
    tick();
    check_done = 1'b0;
    checks++; if (status !== 2'b11) begin errors++; $display("FAIL tie_status actual=%0d expected=3", status); end
    move_req = 1'b1;
    tick();
    move_req = 1'b0;
    checks++; if (move_ack !== 1'b0) begin errors++; $display("FAIL over_ignore_move actual=%0d expected=0", move_ack); end
    tick(); tick();
    checks++; if ({status, cur_player, move_cnt} !== {2'b11, 2'd0, 3'd4}) begin
      errors++; $display("FAIL tie_hold actual=%b expected=%b", {status, cur_player, move_cnt}, {2'b11, 2'd0, 3'd4});
    end
  endtask

  task automatic test_win_last_cell;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({status, move_cnt} !== {2'b01, 3'd0}) begin
      errors++; $display("FAIL restart actual=%b expected=%b", {status, move_cnt}, {2'b01, 3'd0});
    end
    play_move(1'b0); play_move(1'b0); play_move(1'b0); play_move(1'b1);
    checks++; if (status !== 2'b10) begin errors++; $display("FAIL win_last_status actual=%0d expected=2", status); end
    checks++; if (winner !== 2'd0) begin errors++; $display("FAIL win_last_winner actual=%0d expected=0", winner); end
    checks++; if (move_cnt !== 3'd4) begin errors++; $display("FAIL win_last_cnt actual=%0d expected=4", move_cnt); end
  endtask

  task automatic test_win_early;
    start = 1'b1;
    tick();
    start = 1'b0;
    play_move(1'b0); play_move(1'b1);
    tick(); tick();
    checks++; if (status !== 2'b10) begin errors++; $display("FAIL win_early_status actual=%0d expected=2", status); end
    checks++; if (winner !== 2'd1) begin errors++; $display("FAIL win_early_winner actual=%0d expected=1", winner); end
    checks++; if ({cur_player, move_cnt} !== {2'd1, 3'd2}) begin
      errors++; $display("FAIL win_early_hold actual=%b expected=%b", {cur_player, move_cnt}, {2'd1, 3'd2});
    end
  endtask

  task automatic test_reset_in_check;
    start = 1'b1;
    tick();
    start = 1'b0;
    move_req = 1'b1;
    tick();
    move_req = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++; if ({status, move_cnt, move_ack, check_start} !== 7'd0) begin
      errors++; $display("FAIL async_reset actual=%b expected=0000000", {status, move_cnt, move_ack, check_start});
    end
    tick();
    reset = 1'b0;
    check_done = 1'b1; win_found = 1'b1;
    tick();
    check_done = 1'b0; win_found = 1'b0;
    checks++; if ({status, winner} !== 4'b0000) begin
      errors++; $display("FAIL post_reset_check actual=%b expected=0000", {status, winner});
    end
  endtask

  task automatic test_timeout;
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef MOVE_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      tick();
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_early[%0d] actual=1 expected=0", k); end
    end
    tick();
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_pulse actual=%0d expected=1", timeout); end
    checks++; if ({cur_player, move_cnt} !== {2'd1, 3'd0}) begin
      errors++; $display("FAIL timeout_forfeit actual=%b expected=%b", {cur_player, move_cnt}, {2'd1, 3'd0});
    end
    for (int k = 9; k < 16; k++) begin
      tick();
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_rearm[%0d] actual=1 expected=0", k); end
    end
    move_req = 1'b1; col_full = 1'b0;
    tick();
    move_req = 1'b0;
    checks++; if ({move_ack, timeout} !== 2'b10) begin
      errors++; $display("FAIL expiry_move actual=%b expected=10", {move_ack, timeout});
    end
    checks++; if (cur_player !== 2'd1) begin errors++; $display("FAIL expiry_player actual=%0d expected=1", cur_player); end
`else
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_tied[%0d] actual=1 expected=0", k); end
    end
    checks++; if (cur_player !== 2'd0) begin errors++; $display("FAIL no_forfeit actual=%0d expected=0", cur_player); end
`endif
  endtask

  initial begin
    test_reset();
    test_start();
    test_moves();
    test_reject();
    test_tie();
    test_win_last_cell();
    test_win_early();
    test_reset_in_check();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
